// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - two-bit branch history table with global history; gshare indexing under BHT_GSHARE_EN
module bht_predictor #(
    parameter int IDX_BITS = 6,
    parameter int GHR_BITS = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pred_valid,
    input  logic [31:0]         pred_pc,
    output logic                pred_resp_valid,
    output logic                pred_taken,
    output logic [GHR_BITS-1:0] pred_ghr,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic                upd_br_en,
    input  logic                upd_pred_taken,
    input  logic [GHR_BITS-1:0] upd_ghr,
    output logic                mispredict
);

    localparam int ENTRIES = 1 << IDX_BITS;

    logic [1:0]          table_q [ENTRIES];
    logic [GHR_BITS-1:0] ghr_q;
    logic [GHR_BITS-1:0] ghr_eff;
    logic [IDX_BITS-1:0] ghr_ext;
    logic [IDX_BITS-1:0] lk_idx;
    logic [IDX_BITS-1:0] upd_idx;
    logic [1:0]          upd_ctr;
    logic [1:0]          upd_ctr_next;
    logic [1:0]          lk_ctr;
    logic                unused_bits;

    // History seen by a lookup includes a same-cycle resolution (write-first)
    always_comb begin
        ghr_eff = ghr_q;
        if (upd_valid) begin
            ghr_eff = {ghr_q[GHR_BITS-2:0], upd_br_en};
        end
        ghr_ext = '0;
        ghr_ext[GHR_BITS-1:0] = ghr_eff;
    end

`ifdef BHT_GSHARE_EN
    logic [IDX_BITS-1:0] upd_ghr_ext;

    always_comb begin
        upd_ghr_ext = '0;
        upd_ghr_ext[GHR_BITS-1:0] = upd_ghr;
        lk_idx  = pred_pc[IDX_BITS+1:2] ^ ghr_ext;
        upd_idx = upd_pc[IDX_BITS+1:2] ^ upd_ghr_ext;
    end

    assign unused_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                           upd_pc[31:IDX_BITS+2], upd_pc[1:0]};
`else
    always_comb begin
        lk_idx  = pred_pc[IDX_BITS+1:2];
        upd_idx = upd_pc[IDX_BITS+1:2];
    end

    assign unused_bits = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0],
                           upd_pc[31:IDX_BITS+2], upd_pc[1:0], upd_ghr, ghr_ext};
`endif

    always_comb begin
        upd_ctr      = table_q[upd_idx];
        upd_ctr_next = upd_ctr;
        if (upd_br_en) begin
            if (upd_ctr != 2'b11) upd_ctr_next = upd_ctr + 2'b01;
        end else begin
            if (upd_ctr != 2'b00) upd_ctr_next = upd_ctr - 2'b01;
        end
        lk_ctr = table_q[lk_idx];
        if (upd_valid && (upd_idx == lk_idx)) begin
            lk_ctr = upd_ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
            ghr_q           <= '0;
            pred_resp_valid <= 1'b0;
            pred_taken      <= 1'b0;
            pred_ghr        <= '0;
            mispredict      <= 1'b0;
        end else begin
            if (upd_valid) begin
                table_q[upd_idx] <= upd_ctr_next;
            end
            ghr_q           <= ghr_eff;
            pred_resp_valid <= pred_valid;
            pred_taken      <= pred_valid & lk_ctr[1];
            pred_ghr        <= pred_valid ? ghr_eff : '0;
            mispredict      <= upd_valid & (upd_br_en != upd_pred_taken);
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - directed and random checks of bht_predictor against a counter-array model
module tb_bht_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_resp_valid;
    logic        pred_taken;
    logic [5:0]  pred_ghr;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_br_en;
    logic        upd_pred_taken;
    logic [5:0]  upd_ghr;
    logic        mispredict;

    int checks = 0;
    int errors = 0;

    int cnt [64];
    int ghr;
    int exp_valid, exp_taken, exp_ghr, exp_mis;

    always #5 clk = ~clk;

    bht_predictor #(.IDX_BITS(6), .GHR_BITS(6)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_br_en(upd_br_en),
        .upd_pred_taken(upd_pred_taken), .upd_ghr(upd_ghr),
        .mispredict(mispredict)
    );

    function automatic int base_of(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3f);
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: apply inputs, advance the model, compare registered outputs after the edge
    task automatic cycle(input logic r, input logic pv, input logic [31:0] ppc,
                         input logic uv, input logic [31:0] upc, input logic ubr,
                         input logic upt, input logic [5:0] ughr);
        int g_eff, uidx, lidx;
        rst = r; pred_valid = pv; pred_pc = ppc;
        upd_valid = uv; upd_pc = upc; upd_br_en = ubr; upd_pred_taken = upt; upd_ghr = ughr;
        @(posedge clk);
        if (r) begin
            foreach (cnt[i]) cnt[i] = 1;
            ghr = 0;
            exp_valid = 0; exp_taken = 0; exp_ghr = 0; exp_mis = 0;
        end else begin
            g_eff = uv ? (((ghr << 1) | int'(ubr)) & 63) : ghr;
`ifdef BHT_GSHARE_EN
            uidx = base_of(upc) ^ int'(ughr);
            lidx = base_of(ppc) ^ g_eff;
`else
            uidx = base_of(upc);
            lidx = base_of(ppc);
`endif
            if (uv) cnt[uidx] = ubr ? ((cnt[uidx] < 3) ? cnt[uidx] + 1 : 3)
                                    : ((cnt[uidx] > 0) ? cnt[uidx] - 1 : 0);
            exp_valid = int'(pv);
            exp_taken = (pv && cnt[lidx] >= 2) ? 1 : 0;
            exp_ghr   = pv ? g_eff : 0;
            exp_mis   = (uv && ubr != upt) ? 1 : 0;
            ghr = g_eff;
        end
        #1;
        check("pred_resp_valid", int'(pred_resp_valid), exp_valid);
        check("pred_taken", int'(pred_taken), exp_taken);
        check("pred_ghr", int'(pred_ghr), exp_ghr);
        check("mispredict", int'(mispredict), exp_mis);
    endtask

    task automatic lookup(input logic [31:0] pc);
        cycle(1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
    endtask

    task automatic update(input logic [31:0] pc, input logic br, input logic pt, input logic [5:0] g);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, pc, br, pt, g);
    endtask

    initial begin
        int seq_exp [5];
        seq_exp = '{1, 1, 1, 1, 0};
        foreach (cnt[i]) cnt[i] = 1;
        ghr = 0;

        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 6'h0);

        lookup(32'h100);
        check("reset_lookup_taken", int'(pred_taken), 0);

`ifndef BHT_GSHARE_EN
        for (int k = 0; k < 5; k++) begin
            update(32'h100, (k < 3) ? 1'b1 : 1'b0, 1'b0, 6'h0);
            lookup(32'h100);
            check("train_seq", int'(pred_taken), seq_exp[k]);
        end
`endif

        update(32'h104, 1'b1, 1'b0, 6'h0);
        check("mispredict_set", int'(mispredict), 1);
        update(32'h104, 1'b1, 1'b1, 6'h0);
        check("mispredict_clear", int'(mispredict), 0);

        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
        cycle(1'b0, 1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0, 6'h0);
`ifndef BHT_GSHARE_EN
        check("bypass_same_cycle", int'(pred_taken), 1);
        lookup(32'h100);
        check("alias_0x100", int'(pred_taken), 1);
`endif

`ifdef BHT_GSHARE_EN
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
        update(32'h100, 1'b1, 1'b0, 6'h0);
        lookup(32'h104);
        check("gshare_taken", int'(pred_taken), 1);
        check("gshare_ghr", int'(pred_ghr), 1);
`endif

        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
        for (int k = 0; k < 3; k++) update(32'h100, 1'b1, 1'b1, 6'h0);
        cycle(1'b1, 1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 1'b0, 6'h0);
        check("rst_drops_lookup", int'(pred_resp_valid), 0);
        lookup(32'h100);
        check("rst_table_cleared", int'(pred_taken), 0);

        for (int n = 0; n < 400; n++) begin
            cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                  1'($urandom), {22'h0, 8'($urandom_range(0, 15)), 2'($urandom)},
                  1'($urandom), {22'h0, 8'($urandom_range(0, 15)), 2'($urandom)},
                  1'($urandom), 1'($urandom), 6'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
